// File: rtl/tinker_issue_scheduler.sv
// In-order issue controller: SC ops write back via the ALU path, MC ops go to one shared multi-cycle unit.
// Optional perf counters (stall_cnt/issue_cnt) exist only when TINKER_SCHED_PERF_EN is defined.
module tinker_issue_scheduler #(
   parameter int DATA_W      = 64,
   parameter int TIMEOUT_CYC = 255
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [31:0]       in_instr,
   output logic [31:0]       alu_instr,
   input  logic [DATA_W-1:0] alu_result,
   output logic              mc_start,
   output logic [31:0]       mc_instr,
   input  logic              mc_done,
   input  logic [DATA_W-1:0] mc_result,
   output logic              wb_en,
   output logic [4:0]        wb_addr,
   output logic [DATA_W-1:0] wb_data,
   output logic              busy,
   output logic              err
`ifdef TINKER_SCHED_PERF_EN
   ,
   output logic [31:0]       stall_cnt,
   output logic [31:0]       issue_cnt
`endif
);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_MC_WAIT = 2'd1,
      S_ERR     = 2'd2
   } state_t;

   localparam logic [15:0] CNT_LAST = 16'(TIMEOUT_CYC - 1);

   state_t      r_state;
   state_t      w_state_nxt;
   logic [4:0]  r_pend_rd;
   logic [15:0] r_cnt;

   logic [4:0]  w_opc;
   logic [4:0]  w_rd;
   logic [4:0]  w_rs;
   logic [4:0]  w_rt;
   logic        w_is_mc;
   logic        w_hazard;
   logic        w_accept;
   logic        w_timeout;

   assign w_opc     = in_instr[31:27];
   assign w_rd      = in_instr[26:22];
   assign w_rs      = in_instr[21:17];
   assign w_rt      = in_instr[16:12];
   assign alu_instr = in_instr;

   assign w_is_mc = (w_opc inside {5'h14, 5'h15, 5'h16, 5'h17, 5'h1C, 5'h1D});

   // Conservative: any operand or destination matching the pending rd blocks issue.
   assign w_hazard  = (r_state == S_MC_WAIT) &&
                      ((w_rs == r_pend_rd) || (w_rt == r_pend_rd) || (w_rd == r_pend_rd));
   assign w_timeout = (r_state == S_MC_WAIT) && !mc_done && (r_cnt == CNT_LAST);
   assign w_accept  = in_valid && in_ready;

   always_ff @(posedge clk) begin
      if (!rst) r_state <= S_IDLE;
      else      r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      in_ready    = 1'b1;
      if (!rst || (r_state == S_ERR))           in_ready = 1'b0;
      if (w_is_mc && (r_state != S_IDLE))       in_ready = 1'b0;
      if (w_hazard)                             in_ready = 1'b0;
      // The MCU result owns the single write port on the cycle after mc_done.
      if (!w_is_mc && mc_done)                  in_ready = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (in_valid && in_ready && w_is_mc) w_state_nxt = S_MC_WAIT;
         end
         S_MC_WAIT: begin
            if (mc_done)        w_state_nxt = S_IDLE;
            else if (w_timeout) w_state_nxt = S_ERR;
         end
         S_ERR:   w_state_nxt = S_ERR;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         wb_en     <= 1'b0;
         wb_addr   <= '0;
         wb_data   <= '0;
         mc_start  <= 1'b0;
         mc_instr  <= '0;
         busy      <= 1'b0;
         err       <= 1'b0;
         r_pend_rd <= '0;
         r_cnt     <= '0;
      end else begin
         wb_en    <= 1'b0;
         mc_start <= 1'b0;
         if (r_state == S_MC_WAIT) begin
            if (mc_done) begin
               wb_en   <= 1'b1;
               wb_addr <= r_pend_rd;
               wb_data <= mc_result;
               busy    <= 1'b0;
            end else begin
               r_cnt <= r_cnt + 16'd1;
            end
         end
         if (w_timeout) err <= 1'b1;
         if (w_accept) begin
            if (w_is_mc) begin
               mc_start  <= 1'b1;
               mc_instr  <= in_instr;
               r_pend_rd <= w_rd;
               r_cnt     <= '0;
               busy      <= 1'b1;
            end else begin
               wb_en   <= 1'b1;
               wb_addr <= w_rd;
               wb_data <= alu_result;
            end
         end
      end
   end

`ifdef TINKER_SCHED_PERF_EN
   always_ff @(posedge clk) begin
      if (!rst) begin
         stall_cnt <= '0;
         issue_cnt <= '0;
      end else begin
         if (in_valid && !in_ready && (stall_cnt != 32'hFFFF_FFFF)) stall_cnt <= stall_cnt + 32'd1;
         if (w_accept && (issue_cnt != 32'hFFFF_FFFF))              issue_cnt <= issue_cnt + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_tinker_issue_scheduler.sv
// Directed scenarios then randomized traffic, all checked against a transaction-level model.
module tb_tinker_issue_scheduler;
   localparam int DW = 64;
   localparam int TO = 4;

   logic          clk = 1'b0;
   logic          rst, in_valid, mc_done;
   logic [31:0]   in_instr;
   logic [DW-1:0] alu_result, mc_result;
   logic          in_ready, mc_start, wb_en, busy, err;
   logic [31:0]   alu_instr, mc_instr;
   logic [4:0]    wb_addr;
   logic [DW-1:0] wb_data;

   int total = 0;
   int bad   = 0;

   // Model: one outstanding MC op (m_pend) with destination m_rd, waiting m_wait cycles.
   bit            m_pend, m_err;
   logic [4:0]    m_rd;
   int            m_wait;
   logic          e_wb_en, e_mc_start, e_busy;
   logic [4:0]    e_wb_addr;
   logic [DW-1:0] e_wb_data;
   logic [31:0]   e_mc_instr;

   logic [4:0]    ops [10] = '{5'h14, 5'h15, 5'h16, 5'h17, 5'h1C, 5'h1D, 5'h18, 5'h19, 5'h1A, 5'h00};

   tinker_issue_scheduler #(.DATA_W(DW), .TIMEOUT_CYC(TO)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
      .alu_instr(alu_instr), .alu_result(alu_result), .mc_start(mc_start), .mc_instr(mc_instr),
      .mc_done(mc_done), .mc_result(mc_result), .wb_en(wb_en), .wb_addr(wb_addr),
      .wb_data(wb_data), .busy(busy), .err(err)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] mk(input logic [4:0] op, input logic [4:0] rd,
                                      input logic [4:0] rs, input logic [4:0] rt);
      return {op, rd, rs, rt, 12'h0};
   endfunction

   function automatic bit is_mc_op(input logic [4:0] op);
      return (op >= 5'h14 && op <= 5'h17) || op == 5'h1C || op == 5'h1D;
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_pend = 0; m_err = 0; m_rd = '0; m_wait = 0;
      e_wb_en = 0; e_mc_start = 0; e_busy = 0; e_wb_addr = '0; e_wb_data = '0; e_mc_instr = '0;
   endtask

   // Called at a negedge with inputs already driven; returns at the following negedge.
   task automatic step();
      logic [4:0] op, rd, rs, rt;
      bit mc, rdy, acc;
      #1;
      op = in_instr[31:27]; rd = in_instr[26:22]; rs = in_instr[21:17]; rt = in_instr[16:12];
      mc  = is_mc_op(op);
      rdy = rst && !m_err && !(mc && m_pend) &&
            !(m_pend && (rs == m_rd || rt == m_rd || rd == m_rd)) && !(!mc && mc_done);
      chk("in_ready", in_ready, rdy);
      chk("alu_instr", alu_instr, in_instr);
      acc = in_valid && rdy;
      @(posedge clk);
      if (!rst) begin
         model_reset();
      end else begin
         e_wb_en = 0; e_mc_start = 0;
         if (m_pend && mc_done) begin
            e_wb_en = 1; e_wb_addr = m_rd; e_wb_data = mc_result; e_busy = 0; m_pend = 0;
         end else if (m_pend) begin
            m_wait++;
            if (m_wait == TO) begin m_err = 1; m_pend = 0; end
         end
         if (acc && mc) begin
            m_pend = 1; m_rd = rd; m_wait = 0; e_mc_start = 1; e_mc_instr = in_instr; e_busy = 1;
         end else if (acc) begin
            e_wb_en = 1; e_wb_addr = rd; e_wb_data = alu_result;
         end
      end
      @(negedge clk);
      chk("wb_en", wb_en, e_wb_en);
      chk("wb_addr", wb_addr, e_wb_addr);
      chk("wb_data", wb_data, e_wb_data);
      chk("mc_start", mc_start, e_mc_start);
      chk("mc_instr", mc_instr, e_mc_instr);
      chk("busy", busy, e_busy);
      chk("err", err, m_err);
   endtask

   initial begin
      model_reset();
      rst = 0; in_valid = 0; mc_done = 1; in_instr = '0; alu_result = '0; mc_result = 64'h55;
      @(negedge clk);
      // T1: reset held with mc_done asserted
      repeat (3) step();
      rst = 1; mc_done = 0;
      #1 chk("t1_ready_after_rst", in_ready, 1'b1);
      step();

      // T2: back-to-back SC writes
      in_valid = 1; in_instr = mk(5'h18, 5'd3, 5'd1, 5'd2); alu_result = 5;
      step();
      chk("t2_wb0_addr", wb_addr, 3); chk("t2_wb0_data", wb_data, 5);
      in_instr = mk(5'h19, 5'd4, 5'd1, 5'd0); alu_result = 7;
      step();
      chk("t2_wb1_en", wb_en, 1); chk("t2_wb1_addr", wb_addr, 4); chk("t2_wb1_data", wb_data, 7);

      // T3: RAW hazard on MUL destination
      in_instr = mk(5'h1C, 5'd7, 5'd1, 5'd2);
      step();
      chk("t3_mc_start", mc_start, 1);
      in_instr = mk(5'h18, 5'd8, 5'd7, 5'd1); alu_result = 99;
      step(); step();
      mc_done = 1; mc_result = 42;
      step();
      chk("t3_wb_addr", wb_addr, 7); chk("t3_wb_data", wb_data, 42); chk("t3_busy", busy, 0);
      mc_done = 0;
      step();
      chk("t3_add_wb", wb_addr, 8); chk("t3_add_data", wb_data, 99);

      // T4: independent SC during MC, then write-port collision
      in_instr = mk(5'h17, 5'd2, 5'd1, 5'd1);
      step();
      in_instr = mk(5'h1A, 5'd9, 5'd1, 5'd1); alu_result = 11;
      step();
      chk("t4_sub_in_wait", wb_addr, 9);
      in_instr = mk(5'h1A, 5'd10, 5'd1, 5'd1); alu_result = 12; mc_done = 1; mc_result = 64'hABCD;
      step();
      chk("t4_mc_first_addr", wb_addr, 2); chk("t4_mc_first_data", wb_data, 64'hABCD);
      mc_done = 0;
      step();
      chk("t4_sub_second", wb_addr, 10); chk("t4_sub_second_data", wb_data, 12);

      // T5: timeout
      in_instr = mk(5'h16, 5'd5, 5'd1, 5'd1);
      step();
      in_valid = 0;
      repeat (3) step();
      chk("t5_err_early", err, 0);
      step();
      chk("t5_err", err, 1); chk("t5_busy", busy, 1);
      in_valid = 1; in_instr = mk(5'h18, 5'd1, 5'd2, 5'd3);
      step();
      rst = 0; step(); rst = 1;
      chk("t5_err_cleared", err, 0);

      // T6: reset abandons an in-flight op
      in_instr = mk(5'h1C, 5'd6, 5'd1, 5'd2);
      step();
      in_valid = 0; rst = 0;
      step();
      rst = 1; mc_done = 1;
      step();
      chk("t6_no_wb", wb_en, 0); chk("t6_busy", busy, 0);
      mc_done = 0;
      step();

      // Randomized traffic
      for (int i = 0; i < 3000; i++) begin
         in_valid   = ($urandom_range(0, 3) != 0);
         in_instr   = mk(ops[$urandom_range(0, 9)], 5'($urandom_range(0, 7)),
                         5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
         alu_result = {$urandom, $urandom};
         mc_result  = {$urandom, $urandom};
         mc_done    = m_pend ? ($urandom_range(0, 9) < 4) : ($urandom_range(0, 19) == 0);
         rst        = m_err ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 199) != 0);
         step();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
